// File: rtl/bfp_shift_det.sv
// Block-floating-point shift detector.
// Measures the smallest headroom over the complex samples of one frame.
// Headroom is the number of redundant sign bits below the MSB, capped at 3.
// It reports that headroom as the left-shift code for the normalizer.
module bfp_shift_det #(
    parameter int nb  = 16,
    parameter int NPT = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START,
    input  logic [nb+2:0] DR,
    input  logic [nb+2:0] DI,
    output logic [1:0]    SHIFT,
    output logic          RDY,
    output logic          BUSY
);

    localparam int             LW   = $clog2(NPT);
    localparam logic [LW-1:0]  LAST = LW'(NPT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [LW-1:0] cnt, cnt_nxt;
    logic [1:0]    rmin, rmin_nxt;
    logic [1:0]    shift_nxt;
    logic          rdy_nxt;
    logic [1:0]    hs;
    logic [1:0]    hmin;

    // Redundant sign bits directly below the sign bit, saturated at 3.
    function automatic logic [1:0] headroom(input logic [nb+2:0] x);
        logic [1:0] h;
        if (x[nb+1] != x[nb+2])
            h = 2'd0;
        else if (x[nb] != x[nb+2])
            h = 2'd1;
        else if (x[nb-1] != x[nb+2])
            h = 2'd2;
        else
            h = 2'd3;
        return h;
    endfunction

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign hs   = min2(headroom(DR), headroom(DI));
    assign hmin = min2(rmin, hs);
    assign BUSY = (state == ACC);

    // Next-state logic: START always restarts, and the last sample publishes the result.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rmin_nxt  = rmin;
        shift_nxt = SHIFT;
        rdy_nxt   = RDY;
        if (ED) begin
            rdy_nxt = 1'b0;
            if (START) begin
                state_nxt = ACC;
                cnt_nxt   = LW'(1);
                rmin_nxt  = hs;
            end else if (state == ACC) begin
                if (cnt == LAST) begin
                    shift_nxt = hmin;
                    rdy_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    rmin_nxt  = 2'd3;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt  = cnt + LW'(1);
                    rmin_nxt = hmin;
                end
            end
        end
    end

    // State, counter, running minimum and result registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            rmin  <= 2'd3;
            SHIFT <= 2'd0;
            RDY   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rmin  <= rmin_nxt;
            SHIFT <= shift_nxt;
            RDY   <= rdy_nxt;
        end
    end

endmodule

// File: tb/tb_bfp_shift_det.sv
// Directed bench for bfp_shift_det (nb=16, NPT=64) with a result scoreboard.
module tb_bfp_shift_det;

    localparam int NB  = 16;
    localparam int NPT = 64;
    localparam int W   = NB + 3;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         ED = 1'b0;
    logic         START = 1'b0;
    logic [W-1:0] DR = '0;
    logic [W-1:0] DI = '0;
    logic [1:0]   SHIFT;
    logic         RDY;
    logic         BUSY;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_busy = 0, m_cnt = 0, m_min = 3, m_rdy = 0, m_shift = 0;
    int exp_q[$];

    bfp_shift_det #(.nb(NB), .NPT(NPT)) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START),
        .DR(DR), .DI(DI), .SHIFT(SHIFT), .RDY(RDY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Largest k<=3 for which a k-bit left shift is lossless.
    function automatic int hm(input logic [W-1:0] x);
        logic signed [W-1:0] s, t, u;
        int h;
        h = 0;
        s = x;
        for (int k = 1; k <= 3; k++) begin
            t = s <<< k;
            u = t >>> k;
            if (u == s) h = k;
        end
        return h;
    endfunction

    task automatic cyc(input logic ed, input logic st, input logic [W-1:0] dr, input logic [W-1:0] di);
        int hs;
        bit newres;
        ED = ed; START = st; DR = dr; DI = di;
        @(posedge CLK);
        #1;
        newres = 1'b0;
        if (ed) begin
            hs = (hm(dr) < hm(di)) ? hm(dr) : hm(di);
            if (st) begin
                m_busy = 1; m_cnt = 1; m_min = hs; m_rdy = 0;
            end else if (m_busy != 0) begin
                if (hs < m_min) m_min = hs;
                m_cnt++;
                if (m_cnt == NPT) begin
                    exp_q.push_back(m_min);
                    m_rdy = 1; m_busy = 0; m_cnt = 0; m_min = 3;
                    newres = 1'b1;
                end else begin
                    m_rdy = 0;
                end
            end else begin
                m_rdy = 0;
            end
        end
        chk("rdy", 32'(RDY), 32'(m_rdy));
        chk("busy", 32'(BUSY), 32'(m_busy));
        if (newres) begin
            m_shift = exp_q.pop_front();
            chk("shift_result", 32'(SHIFT), 32'(m_shift));
        end else begin
            chk("shift_hold", 32'(SHIFT), 32'(m_shift));
        end
    endtask

    task automatic frame(input int n, input int sidx, input logic [W-1:0] sdr, input logic [W-1:0] sdi,
                         input logic [W-1:0] base, input bit rnd_ed);
        for (int i = 0; i < n; i++) begin
            if (rnd_ed) begin
                for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++)
                    cyc(1'b0, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            end
            cyc(1'b1, i == 0, (i == sidx) ? sdr : base, (i == sidx) ? sdi : base);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #1;
        m_busy = 0; m_cnt = 0; m_min = 3; m_rdy = 0; m_shift = 0;
        exp_q.delete();
        chk("rst_shift", 32'(SHIFT), 32'd0);
        chk("rst_rdy", 32'(RDY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        chk("rst_busy_clk", 32'(BUSY), 32'd0);
        RST = 1'b1;
    endtask

    initial begin
        #3;
        do_reset();

        // Small positive samples: full headroom
        frame(NPT, -1, '0, '0, 19'h00100, 1'b0);
        chk("allsmall_shift", 32'(SHIFT), 32'd3);
        chk("allsmall_rdy", 32'(RDY), 32'd1);
        chk("allsmall_busy", 32'(BUSY), 32'd0);
        cyc(1'b1, 1'b0, '0, '0);
        chk("rdy_clear", 32'(RDY), 32'd0);

        // One sample limits the frame
        frame(NPT, 40, 19'h08000, 19'h00000, 19'h00000, 1'b0);
        chk("s40_shift", 32'(SHIFT), 32'd2);
        frame(NPT, 5, 19'h00000, 19'h40000, 19'h00000, 1'b0);
        chk("s5_shift", 32'(SHIFT), 32'd0);
        frame(NPT, -1, '0, '0, 19'h7FFFF, 1'b0);
        chk("allm1_shift", 32'(SHIFT), 32'd3);
        frame(NPT, 10, 19'h60000, 19'h00000, 19'h00000, 1'b0);
        chk("h1_shift", 32'(SHIFT), 32'd1);

        // Abort at sample 30: old frame must not publish
        frame(30, -1, '0, '0, 19'h40000, 1'b0);
        chk("abort_hold_shift", 32'(SHIFT), 32'd1);
        frame(NPT, -1, '0, '0, 19'h00000, 1'b0);
        chk("restart_shift", 32'(SHIFT), 32'd3);

        // START on what would be the last sample of the old frame
        frame(NPT - 1, -1, '0, '0, 19'h40000, 1'b0);
        frame(NPT, -1, '0, '0, 19'h08000, 1'b0);
        chk("last_start_shift", 32'(SHIFT), 32'd2);

        // Random ED gaps with garbage data on ED=0 cycles
        frame(NPT, -1, '0, '0, 19'h10000, 1'b1);
        chk("ed_gap_shift", 32'(SHIFT), 32'd1);
        cyc(1'b0, 1'b0, 19'h40000, 19'h40000);
        chk("ed0_hold_rdy", 32'(RDY), 32'd1);
        chk("ed0_hold_shift", 32'(SHIFT), 32'd1);

        // Idle samples without START are ignored
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 19'h40000, 19'h40000);
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Reset in the middle of a frame
        frame(20, -1, '0, '0, 19'h00000, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 19'h40000, 19'h00000);
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_rdy", 32'(RDY), 32'd0);
        frame(NPT, -1, '0, '0, 19'h0C000, 1'b0);
        chk("post_rst_shift", 32'(SHIFT), 32'd2);
        chk("post_rst_rdy_end", 32'(RDY), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bfp_shift_det.md
BFP_SHIFT_DET -- requirements
Module: bfp_shift_det

Interface
REQ-001 The block SHALL have parameter nb, default 16, giving the base data width; data ports are nb+3 bits wide.
REQ-002 The block SHALL have parameter NPT, default 64, giving samples per frame; it must be a power of two, at least 4.
REQ-003 CLK  in  1  the single clock; all registers update on the rising edge.
REQ-004 RST  in  1  asynchronous, active-low reset.
REQ-005 ED  in  1  enable; the block samples inputs and updates registers only in cycles with ED=1.
REQ-006 START  in  1  frame start; it arrives with sample 0 of a frame.
REQ-007 DR  in  nb+3  real part of a sample, two's complement.
REQ-008 DI  in  nb+3  imaginary part of a sample, two's complement.
REQ-009 SHIFT  out  2  left-shift code (0..3) for the frame just measured; it drives the SHIFT input of the normalization unit.
REQ-010 RDY  out  1  result-valid strobe for SHIFT.
REQ-011 BUSY  out  1  high while a frame is being measured.

Function
REQ-012 Headroom h(x) of a word x SHALL be the number of consecutive bits, counted downward from bit nb+1, that equal sign bit nb+2, capped at 3.
REQ-013 Sample headroom SHALL be min(h(DR), h(DI)).
REQ-014 Frame headroom SHALL be the minimum sample headroom over all NPT samples of the frame.
REQ-015 A left shift by SHIFT SHALL never lose a significant bit: bits [nb+2 : nb+2-SHIFT] are equal for every sample in the frame.
REQ-016 The block SHALL have two states, IDLE and ACC, held in a registered state variable.
REQ-017 In an ED=1 cycle with START=1, in either state, the block SHALL take the present sample as sample 0: sample counter <= 1, running min <= sample headroom, state <= ACC.
REQ-018 In ACC, in an ED=1 cycle with START=0, the block SHALL accept one sample: running min <= min(running min, sample headroom), counter increments.
REQ-019 The block SHALL treat the sample accepted with counter = NPT-1 as the last sample of the frame.
REQ-020 On the last sample, the block SHALL register min(running min, sample headroom) into SHIFT, set RDY=1, clear the counter to 0, and go to IDLE.
REQ-021 Result latency SHALL be one ED=1 clock: SHIFT and RDY are valid on the edge that accepts the last sample.
REQ-022 RDY SHALL be cleared by the next ED=1 cycle, unless that cycle ends another frame; while ED=0, RDY and SHIFT SHALL hold.
REQ-023 SHIFT SHALL hold its value until the next completed frame; an aborted frame SHALL not change it.
REQ-024 START in ACC SHALL abort the current frame with no RDY and restart per REQ-017.
REQ-025 START on the last-sample cycle SHALL take precedence: the frame is aborted and a new frame starts with no RDY.
REQ-026 In IDLE, samples with START=0 SHALL be ignored and the running min SHALL hold at 3.
REQ-027 An all-zero or all-minus-one frame SHALL yield SHIFT=3.
REQ-028 The counter SHALL be log2(NPT) bits wide, wrap to 0 at frame end, and never count in IDLE.
REQ-029 BUSY SHALL be 1 exactly when the state is ACC.
REQ-030 ED=0 cycles SHALL not be counted and SHALL not contribute headroom.

Reset
REQ-031 While RST=0, asynchronously: SHIFT=0, RDY=0, BUSY=0, state=IDLE, counter=0, running min=3.
REQ-032 Reset mid-frame SHALL discard the partial frame; after release, nothing happens until the next START.
REQ-033 Release SHALL be synchronized by the integrator; the first edge after release is a normal cycle.

Verification (nb=16, NPT=64, ED=1 unless stated)
REQ-034 Reset then a frame of 64 samples with DR=DI=19'h00100 -> RDY one cycle after sample 63 is accepted, SHIFT=3, BUSY=0 afterwards.
REQ-035 Frame with sample 40 having DR=19'h08000 and all other samples 19'h00000 -> SHIFT=2; then a frame with sample 5 having DI=19'h40000 -> SHIFT=0.
REQ-036 Frame of all 19'h7FFFF (-1) -> SHIFT=3; frame with one sample 19'h60000 (h=1) -> SHIFT=1.
REQ-037 START reasserted at sample 30 -> no RDY at the old boundary, SHIFT unchanged, RDY exactly 64 accepted samples after the new START.
REQ-038 ED toggling 0/1 randomly through a frame -> RDY only after 64 ED=1 samples; RDY and SHIFT held during ED=0.
REQ-039 RST=0 pulsed at sample 20 -> outputs go to reset values immediately; samples without START are ignored; the next START frame completes normally.
